stopwatch_bcd: RTL and testbench

Parametrised multi-digit BCD stopwatch/timer, the successor to the 4-bit free-running stopwatch counter. It adds a prescaled count tick, an explicit run/pause/done state machine, up or down counting with a load value, wrap-or-saturate end behaviour, and a lap (display-freeze) function. It feeds the seven-segment display driver and the board LEDs.

---
 rtl/stopwatch_bcd_pkg.sv | 17 +
 rtl/stopwatch_bcd_digit.sv | 29 ++
 rtl/stopwatch_bcd.sv | 134 +++++++++++++
 tb/tb_stopwatch_bcd.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_pkg.sv
// Shared constants for the BCD stopwatch: state encoding,
// digit width and the BCD digit ceiling.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch chain; co flags a carry
// (up, 9->0) or borrow (down, 0->9) into the next digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       co
);

  assign co = en && (dir ? (q == 4'd0) : (q == BCD_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 4'd0;
    end else if (load) begin
      q <= bcd_clamp(load_val);
    end else if (en) begin
      if (dir) q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      else     q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Multi-digit BCD stopwatch: prescaler, run/pause/done FSM,
// up/down counting with preset, and a lap display freeze.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter bit WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    lap,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    lap_active,
  output logic                    done,
  output logic                    tick
);

  localparam int CW = BCD_W * NUM_DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ALL9 = {NUM_DIGITS{BCD_MAX}};

  logic [1:0]            state;
  logic [PW-1:0]         presc;
  logic                  dir_q;
  logic [CW-1:0]         snap;
  logic                  ld;
  logic                  zero;
  logic                  step;
  logic                  sat;
  logic                  last;
  logic                  dig_ld;
  logic [CW-1:0]         dig_lv;
  logic [NUM_DIGITS-1:0] en;
  logic [NUM_DIGITS-1:0] co;

  assign ld   = load && (state != RUN);
  assign zero = (count == '0);
  assign tick = (state == RUN) && !pause && !reset
             && (presc == PMAX);

  // Down never steps below zero.
  assign step = tick && !(dir_q && zero);

  // A carry out of the top digit is a full roll-over;
  // without WRAP the digits are reloaded with all 9s.
  assign sat    = co[NUM_DIGITS-1] && !WRAP;
  assign last   = step && dir_q && (count == CW'(1));
  assign dig_ld = ld || sat;
  assign dig_lv = ld ? load_val : ALL9;

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
      if (i == 0) begin : g_lsd
        assign en[i] = step;
      end else begin : g_up
        assign en[i] = co[i-1];
      end
      bcd_digit u_dig (
        .clk      (clk),
        .reset    (reset),
        .en       (en[i]),
        .dir      (dir_q),
        .load     (dig_ld),
        .load_val (dig_lv[i*BCD_W +: BCD_W]),
        .q        (count[i*BCD_W +: BCD_W]),
        .co       (co[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      dir_q <= 1'b0;
    end else if (ld) begin
      state <= IDLE;
      presc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            presc <= '0;
            dir_q <= dir;
            state <= (dir && zero) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else begin
            presc <= (presc == PMAX) ? '0 : presc + 1'b1;
            if (sat || last) state <= DONE;
          end
        end
        PAUSED: begin
          if (start) state <= RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_active <= 1'b0;
      snap       <= '0;
    end else if (ld) begin
      lap_active <= 1'b0;
    end else if (lap) begin
      if (state == RUN) begin
        lap_active <= !lap_active;
        if (!lap_active) snap <= count;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  assign display = lap_active ? snap : count;
  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: a saturating and a wrapping instance
// share stimulus and are tracked by an integer-valued model.
module tb_stopwatch_bcd;

  localparam int ND = 2;
  localparam int CD = 4;

  typedef enum int {S_IDLE, S_RUN, S_PAUSED, S_DONE} st_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       lap = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] count [2];
  logic [7:0] display [2];
  logic       running [2];
  logic       lap_active [2];
  logic       done [2];
  logic       tick [2];

  int n_checks = 0;
  int n_errors = 0;

  st_t m_st [2];
  int  m_val [2];
  int  m_pr [2];
  int  m_snap [2];
  bit  m_la [2];
  bit  m_md [2];

  always #5 clk = ~clk;

  stopwatch_bcd #(.NUM_DIGITS(ND), .CLK_DIV(CD), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .lap(lap), .dir(dir), .load(load), .load_val(load_val),
    .count(count[0]), .display(display[0]),
    .running(running[0]), .lap_active(lap_active[0]),
    .done(done[0]), .tick(tick[0])
  );

  stopwatch_bcd #(.NUM_DIGITS(ND), .CLK_DIV(CD), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .lap(lap), .dir(dir), .load(load), .load_val(load_val),
    .count(count[1]), .display(display[1]),
    .running(running[1]), .lap_active(lap_active[1]),
    .done(done[1]), .tick(tick[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int preset(input logic [7:0] lv);
    int hi;
    int lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic m_step(input int k);
    bit wrap;
    wrap = (k == 1);
    if (reset) begin
      m_st[k] = S_IDLE; m_val[k] = 0; m_pr[k] = 0;
      m_snap[k] = 0; m_la[k] = 0; m_md[k] = 0;
    end else if (load && m_st[k] != S_RUN) begin
      m_val[k] = preset(load_val);
      m_pr[k] = 0; m_st[k] = S_IDLE; m_la[k] = 0;
    end else begin
      if (lap) begin
        if (m_st[k] == S_RUN) begin
          if (!m_la[k]) m_snap[k] = m_val[k];
          m_la[k] = !m_la[k];
        end else begin
          m_la[k] = 0;
        end
      end
      case (m_st[k])
        S_IDLE: if (start) begin
          m_pr[k] = 0;
          m_md[k] = dir;
          m_st[k] = (dir && m_val[k] == 0) ? S_DONE : S_RUN;
        end
        S_RUN: if (pause) begin
          m_st[k] = S_PAUSED;
        end else if (m_pr[k] == CD - 1) begin
          m_pr[k] = 0;
          if (!m_md[k]) begin
            if (m_val[k] == 99) begin
              if (wrap) m_val[k] = 0;
              else m_st[k] = S_DONE;
            end else begin
              m_val[k]++;
            end
          end else if (m_val[k] > 0) begin
            m_val[k]--;
            if (m_val[k] == 0) m_st[k] = S_DONE;
          end
        end else begin
          m_pr[k]++;
        end
        S_PAUSED: if (start) m_st[k] = S_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    bit et;
    for (int k = 0; k < 2; k++) begin
      et = (m_st[k] == S_RUN) && !pause && !reset
        && (m_pr[k] == CD - 1);
      chk($sformatf("count%0d", k), 32'(count[k]),
          32'(bcd(m_val[k])));
      chk($sformatf("display%0d", k), 32'(display[k]),
          32'(bcd(m_la[k] ? m_snap[k] : m_val[k])));
      chk($sformatf("flags%0d", k),
          32'({running[k], done[k], lap_active[k], tick[k]}),
          32'({m_st[k] == S_RUN, m_st[k] == S_DONE, m_la[k], et}));
    end
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic p, input logic l,
                     input logic d, input logic ld,
                     input logic [7:0] lv);
    @(negedge clk);
    reset = r; start = s; pause = p; lap = l;
    dir = d; load = ld; load_val = lv;
    #1;
    compare();
    for (int k = 0; k < 2; k++) m_step(k);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic pchk(input string tag, input int k,
                      input logic [7:0] c,
                      input logic r, input logic dn);
    chk(tag, 32'({count[k], running[k], done[k]}),
        32'({c, r, dn}));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) m_step(k);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      pchk("reset", k, 8'h00, 1'b0, 1'b0);
      chk("reset_all", 32'({display[k], lap_active[k], tick[k]}), 0);
    end

    // up-count from zero, ten ticks in forty run cycles
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(40);
    settle();
    pchk("up10", 1, 8'h10, 1'b1, 1'b0);

    // pause mid-prescaler at 58, resume without re-zero
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h57);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(5);
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    idle(20);
    settle();
    pchk("hold58", 1, 8'h58, 1'b0, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(12);

    // roll-over: wrap instance wraps, saturating one stops
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h97);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(12);
    settle();
    pchk("wrap00", 1, 8'h00, 1'b1, 1'b0);
    pchk("sat99", 0, 8'h99, 1'b0, 1'b1);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    settle();
    pchk("load00", 0, 8'h00, 1'b0, 1'b0);

    // down-count to zero, then start-down from zero
    cyc(0, 0, 0, 0, 0, 1, 8'h03);
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    idle(12);
    settle();
    pchk("down0", 1, 8'h00, 1'b0, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    settle();
    pchk("zdone", 0, 8'h00, 1'b0, 1'b1);

    // lap freeze and release, then lap on a tick edge
    cyc(0, 0, 0, 0, 0, 1, 8'h25);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(2);
    cyc(0, 0, 0, 1, 0, 0, 8'h00);
    idle(20);
    settle();
    chk("lapfreeze", 32'({display[1], count[1]}), 32'(16'h2530));
    cyc(0, 0, 0, 1, 0, 0, 8'h00);
    idle(3);
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h25);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(3);
    cyc(0, 0, 0, 1, 0, 0, 8'h00);
    settle();
    chk("laptick", 32'({display[1], count[1]}), 32'(16'h2526));

    // start+pause, ignored load in RUN, reset mid-run
    cyc(0, 1, 1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h11);
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h45);
    cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle(8);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    settle();
    pchk("rst47", 1, 8'h00, 1'b0, 1'b0);
    chk("rst_all", 32'({display[1], lap_active[1], tick[1]}), 0);

    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 11) == 0,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 24) == 0,
          8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
